exe_stage: RTL and testbench

Execute stage of the 5-stage ARM-subset pipeline. Consumes the registered ID/EX outputs: decoded control, operands, shifter operand, 24-bit branch immediate, destination and condition flags. It computes the second operand, ALU result and branch target. It owns the architectural status register {N,Z,C,V} and registers all results into the EX/MEM boundary for the memory stage.

---
 rtl/exe_stage.sv | 149 ++++++++++++++
 tb/tb_exe_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: shifter operand, ALU, flags, branch target, EX/MEM register
//
// Purpose: computes the second ALU operand (rotated immediate, zero-extended
// memory offset or shifted register), the ALU result and {N,Z,C,V} flags,
// the branch target, and registers results into the EX/MEM boundary.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   freeze                   holds EX/MEM register, blocks status write
//   *_in                     decoded instruction fields from ID/EX
//   status_out               architectural status register {N,Z,C,V}
//   branch_taken/address     combinational branch decision and target
//   wb/mem enables, ALU_result, Val_Rm, Dest   registered EX/MEM outputs
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_enable_in,
  input  logic        mem_read_enable_in,
  input  logic        mem_write_enable_in,
  input  logic        branch_enable_in,
  input  logic        S_in,
  input  logic [3:0]  exec_cmd_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  input  logic        immidiate_in,
  input  logic [11:0] Shift_operand_in,
  input  logic [23:0] Signed_immidiate_24_in,
  input  logic [3:0]  Dest_in,
  input  logic [3:0]  Status_in,
  output logic [3:0]  status_out,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic        wb_enable,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] ALU_result,
  output logic [31:0] Val_Rm,
  output logic [3:0]  Dest
);

  logic [31:0] val2;
  logic [31:0] imm_zext;
  logic [63:0] imm_rot;
  logic [63:0] rm_rot;
  logic [4:0]  rot_amt;
  logic [4:0]  shift_imm;

  logic [31:0] alu_res;
  logic [32:0] sum33;
  logic        cin;
  logic        n_flag, z_flag, c_flag, v_flag;

  assign imm_zext  = {24'd0, Shift_operand_in[7:0]};
  assign rot_amt   = {Shift_operand_in[11:8], 1'b0};
  assign shift_imm = Shift_operand_in[11:7];
  assign cin       = Status_in[1];

  // Rotations are done by shifting a doubled copy right; the low word is the
  // rotated value and a zero amount naturally returns the input unchanged.
  assign imm_rot = {imm_zext, imm_zext} >> rot_amt;
  assign rm_rot  = {Val_Rm_in, Val_Rm_in} >> shift_imm;

  always_comb begin
    val2 = 32'd0;
    if (immidiate_in) begin
      val2 = imm_rot[31:0];
    end else if (mem_read_enable_in || mem_write_enable_in) begin
      val2 = {20'd0, Shift_operand_in};
    end else begin
      case (Shift_operand_in[6:5])
        2'b00:   val2 = Val_Rm_in << shift_imm;
        2'b01:   val2 = Val_Rm_in >> shift_imm;
        2'b10:   val2 = $unsigned($signed(Val_Rm_in) >>> shift_imm);
        default: val2 = rm_rot[31:0];
      endcase
    end
  end

  // Subtraction is A + ~B + carry-in so that the carry out is NOT borrow.
  always_comb begin
    alu_res = 32'd0;
    sum33   = 33'd0;
    c_flag  = Status_in[1];
    v_flag  = Status_in[0];
    case (exec_cmd_in)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011: begin
        sum33   = {1'b0, Val_Rn_in} + {1'b0, val2}
                + {32'd0, (exec_cmd_in[0] & cin)};
        alu_res = sum33[31:0];
        c_flag  = sum33[32];
        v_flag  = (Val_Rn_in[31] == val2[31]) && (alu_res[31] != Val_Rn_in[31]);
      end
      4'b0100, 4'b0101: begin
        sum33   = {1'b0, Val_Rn_in} + {1'b0, ~val2}
                + {32'd0, (exec_cmd_in[0] ? cin : 1'b1)};
        alu_res = sum33[31:0];
        c_flag  = sum33[32];
        v_flag  = (Val_Rn_in[31] != val2[31]) && (alu_res[31] != Val_Rn_in[31]);
      end
      4'b0110: alu_res = Val_Rn_in & val2;
      4'b0111: alu_res = Val_Rn_in | val2;
      4'b1000: alu_res = Val_Rn_in ^ val2;
      default: alu_res = 32'd0;
    endcase
    n_flag = alu_res[31];
    z_flag = (alu_res == 32'd0);
  end

  assign branch_taken   = branch_enable_in;
  assign branch_address = PC_in + {{6{Signed_immidiate_24_in[23]}}, Signed_immidiate_24_in, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      status_out <= 4'd0;
    end else if (S_in && !freeze) begin
      // Undefined opcodes leave the flags as they were sampled in ID.
      case (exec_cmd_in)
        4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100,
        4'b0101, 4'b0110, 4'b0111, 4'b1000:
          status_out <= {n_flag, z_flag, c_flag, v_flag};
        default:
          status_out <= Status_in;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_enable        <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      ALU_result       <= 32'd0;
      Val_Rm           <= 32'd0;
      Dest             <= 4'd0;
    end else if (!freeze) begin
      wb_enable        <= wb_enable_in;
      mem_read_enable  <= mem_read_enable_in;
      mem_write_enable <= mem_write_enable_in;
      ALU_result       <= alu_res;
      Val_Rm           <= Val_Rm_in;
      Dest             <= Dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        wb_enable_in, mem_read_enable_in, mem_write_enable_in, branch_enable_in, S_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic        immidiate_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_immidiate_24_in;
  logic [3:0]  Dest_in, Status_in;
  logic [3:0]  status_out;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        wb_enable, mem_read_enable, mem_write_enable;
  logic [31:0] ALU_result, Val_Rm;
  logic [3:0]  Dest;

  int errors = 0;
  int checks = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_enable_in(wb_enable_in), .mem_read_enable_in(mem_read_enable_in),
    .mem_write_enable_in(mem_write_enable_in), .branch_enable_in(branch_enable_in),
    .S_in(S_in), .exec_cmd_in(exec_cmd_in), .PC_in(PC_in),
    .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .immidiate_in(immidiate_in),
    .Shift_operand_in(Shift_operand_in), .Signed_immidiate_24_in(Signed_immidiate_24_in),
    .Dest_in(Dest_in), .Status_in(Status_in), .status_out(status_out),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .wb_enable(wb_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .ALU_result(ALU_result),
    .Val_Rm(Val_Rm), .Dest(Dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    rst = 0; freeze = 0;
    wb_enable_in = 0; mem_read_enable_in = 0; mem_write_enable_in = 0;
    branch_enable_in = 0; S_in = 0; exec_cmd_in = 4'd0;
    PC_in = 0; Val_Rn_in = 0; Val_Rm_in = 0; immidiate_in = 0;
    Shift_operand_in = 0; Signed_immidiate_24_in = 0; Dest_in = 0; Status_in = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; wb_enable_in = 1; mem_read_enable_in = 1; Dest_in = 4'hA;
    Val_Rm_in = 32'h55; S_in = 1; exec_cmd_in = 4'b1001;
    step(); step();
    checks++;
    if ({wb_enable, mem_read_enable, mem_write_enable, ALU_result, Val_Rm, Dest, status_out} !== 75'd0) begin
      errors++;
      $display("FAIL reset: got ctl=%b%b%b res=%h rm=%h dest=%h st=%b required all zero",
               wb_enable, mem_read_enable, mem_write_enable, ALU_result, Val_Rm, Dest, status_out);
    end
    set_idle();
  endtask

  task automatic test_add_imm();
    set_idle();
    wb_enable_in = 1; S_in = 1; exec_cmd_in = 4'b0010; Val_Rn_in = 5;
    immidiate_in = 1; Shift_operand_in = 12'h007; Dest_in = 4'd3;
    step();
    checks++;
    if (ALU_result !== 32'd12 || status_out !== 4'b0000 || wb_enable !== 1'b1 || Dest !== 4'd3) begin
      errors++;
      $display("FAIL add_imm: got res=%h st=%b wb=%b dest=%h required 0000000c 0000 1 3",
               ALU_result, status_out, wb_enable, Dest);
    end
  endtask

  task automatic test_sub_flags();
    set_idle();
    S_in = 1; exec_cmd_in = 4'b0100; Val_Rn_in = 3; immidiate_in = 1; Shift_operand_in = 12'h003;
    step();
    checks++;
    if (ALU_result !== 32'd0 || status_out !== 4'b0110) begin
      errors++;
      $display("FAIL sub_flags: got res=%h st=%b required 00000000 0110", ALU_result, status_out);
    end
  endtask

  task automatic test_add_overflow();
    set_idle();
    S_in = 1; exec_cmd_in = 4'b0010; Val_Rn_in = 32'h7FFFFFFF; immidiate_in = 1; Shift_operand_in = 12'h001;
    step();
    checks++;
    if (ALU_result !== 32'h80000000 || status_out !== 4'b1001) begin
      errors++;
      $display("FAIL add_overflow: got res=%h st=%b required 80000000 1001", ALU_result, status_out);
    end
  endtask

  task automatic test_adc_sbc();
    set_idle();
    S_in = 1; exec_cmd_in = 4'b0011; Status_in = 4'b0010;
    Val_Rn_in = 32'hFFFFFFFF; immidiate_in = 1; Shift_operand_in = 12'h000;
    step();
    checks++;
    if (ALU_result !== 32'd0 || status_out !== 4'b0110) begin
      errors++;
      $display("FAIL adc_carry: got res=%h st=%b required 00000000 0110", ALU_result, status_out);
    end
    exec_cmd_in = 4'b0101; Status_in = 4'b0000; Val_Rn_in = 5; Shift_operand_in = 12'h003;
    step();
    checks++;
    if (ALU_result !== 32'd1 || status_out !== 4'b0010) begin
      errors++;
      $display("FAIL sbc_borrow: got res=%h st=%b required 00000001 0010", ALU_result, status_out);
    end
  endtask

  task automatic test_logic_flags();
    set_idle();
    S_in = 1; exec_cmd_in = 4'b0110; Status_in = 4'b0011;
    Val_Rn_in = 32'hF0; immidiate_in = 1; Shift_operand_in = 12'h00F;
    step();
    checks++;
    if (ALU_result !== 32'd0 || status_out !== 4'b0111) begin
      errors++;
      $display("FAIL and_keep_cv: got res=%h st=%b required 00000000 0111", ALU_result, status_out);
    end
    exec_cmd_in = 4'b1001; Status_in = 4'b0000; Shift_operand_in = 12'h000;
    step();
    checks++;
    if (ALU_result !== 32'hFFFFFFFF || status_out !== 4'b1000) begin
      errors++;
      $display("FAIL mvn: got res=%h st=%b required ffffffff 1000", ALU_result, status_out);
    end
    exec_cmd_in = 4'b1000; Val_Rn_in = 32'h0000FF00; immidiate_in = 0; Val_Rm_in = 32'h00FFFF00;
    Shift_operand_in = 12'h000;
    step();
    checks++;
    if (ALU_result !== 32'h00FF0000) begin
      errors++;
      $display("FAIL eor: got %h required 00ff0000", ALU_result);
    end
  endtask

  task automatic test_shifter();
    set_idle();
    exec_cmd_in = 4'b0001; immidiate_in = 1; Shift_operand_in = 12'h4FF;
    step();
    checks++;
    if (ALU_result !== 32'hFF000000) begin
      errors++;
      $display("FAIL imm_rotate: got %h required ff000000", ALU_result);
    end
    immidiate_in = 0; Val_Rm_in = 32'h80000000; Shift_operand_in = 12'h240;
    step();
    checks++;
    if (ALU_result !== 32'hF8000000) begin
      errors++;
      $display("FAIL asr4: got %h required f8000000", ALU_result);
    end
    Shift_operand_in = 12'h220;
    step();
    checks++;
    if (ALU_result !== 32'h08000000) begin
      errors++;
      $display("FAIL lsr4: got %h required 08000000", ALU_result);
    end
    Val_Rm_in = 32'h00000001; Shift_operand_in = 12'h200;
    step();
    checks++;
    if (ALU_result !== 32'h00000010) begin
      errors++;
      $display("FAIL lsl4: got %h required 00000010", ALU_result);
    end
    Shift_operand_in = 12'h260;
    step();
    checks++;
    if (ALU_result !== 32'h10000000) begin
      errors++;
      $display("FAIL ror4: got %h required 10000000", ALU_result);
    end
    Val_Rm_in = 32'h12345678; Shift_operand_in = 12'h060;
    step();
    checks++;
    if (ALU_result !== 32'h12345678) begin
      errors++;
      $display("FAIL ror0: got %h required 12345678", ALU_result);
    end
  endtask

  task automatic test_mem_offset();
    set_idle();
    mem_read_enable_in = 1; wb_enable_in = 1; exec_cmd_in = 4'b0010;
    Val_Rn_in = 32'h1000; Shift_operand_in = 12'hABC; Val_Rm_in = 32'hDEADBEEF; Dest_in = 4'd7;
    step();
    checks++;
    if (ALU_result !== 32'h00001ABC || mem_read_enable !== 1'b1 || Val_Rm !== 32'hDEADBEEF || Dest !== 4'd7) begin
      errors++;
      $display("FAIL mem_offset: got res=%h mr=%b rm=%h dest=%h required 00001abc 1 deadbeef 7",
               ALU_result, mem_read_enable, Val_Rm, Dest);
    end
    mem_read_enable_in = 0; mem_write_enable_in = 1; wb_enable_in = 0; Shift_operand_in = 12'hFFF;
    step();
    checks++;
    if (ALU_result !== 32'h00001FFF || mem_write_enable !== 1'b1 || wb_enable !== 1'b0) begin
      errors++;
      $display("FAIL store_offset: got res=%h mw=%b wb=%b required 00001fff 1 0",
               ALU_result, mem_write_enable, wb_enable);
    end
  endtask

  task automatic test_branch();
    set_idle();
    branch_enable_in = 1; PC_in = 32'h100; Signed_immidiate_24_in = 24'hFFFFFE;
    #1;
    checks++;
    if (branch_taken !== 1'b1 || branch_address !== 32'h000000F8) begin
      errors++;
      $display("FAIL branch_back: got taken=%b addr=%h required 1 000000f8", branch_taken, branch_address);
    end
    PC_in = 32'hFFFFFFF0; Signed_immidiate_24_in = 24'h000008;
    #1;
    checks++;
    if (branch_address !== 32'h00000010) begin
      errors++;
      $display("FAIL branch_wrap: got %h required 00000010", branch_address);
    end
    branch_enable_in = 0;
    #1;
    checks++;
    if (branch_taken !== 1'b0) begin
      errors++;
      $display("FAIL branch_not_taken: got %b required 0", branch_taken);
    end
  endtask

  task automatic test_bubble();
    set_idle();
    S_in = 1; exec_cmd_in = 4'b0100; Val_Rn_in = 3; immidiate_in = 1; Shift_operand_in = 12'h003;
    wb_enable_in = 1;
    step();
    set_idle();
    exec_cmd_in = 4'b0001; immidiate_in = 1; Shift_operand_in = 12'h080;
    step();
    checks++;
    if (status_out !== 4'b0110 || wb_enable !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL bubble: got st=%b ctl=%b%b%b required 0110 000",
               status_out, wb_enable, mem_read_enable, mem_write_enable);
    end
  endtask

  task automatic test_back_to_back();
    set_idle();
    wb_enable_in = 1; exec_cmd_in = 4'b0111; Val_Rn_in = 32'hA0; immidiate_in = 1;
    Shift_operand_in = 12'h00B; Dest_in = 4'd1;
    step();
    checks++;
    if (ALU_result !== 32'hAB || Dest !== 4'd1) begin
      errors++;
      $display("FAIL b2b_first: got res=%h dest=%h required 000000ab 1", ALU_result, Dest);
    end
    exec_cmd_in = 4'b0100; Val_Rn_in = 32'd1; Shift_operand_in = 12'h002; Dest_in = 4'd2; S_in = 1;
    step();
    checks++;
    if (ALU_result !== 32'hFFFFFFFF || Dest !== 4'd2 || status_out !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_second: got res=%h dest=%h st=%b required ffffffff 2 1000",
               ALU_result, Dest, status_out);
    end
  endtask

  task automatic test_freeze();
    set_idle();
    wb_enable_in = 1; S_in = 1; exec_cmd_in = 4'b0010; Val_Rn_in = 32'h7FFFFFFF;
    immidiate_in = 1; Shift_operand_in = 12'h001; Dest_in = 4'd9; Val_Rm_in = 32'h1234;
    step();
    freeze = 1; S_in = 1; exec_cmd_in = 4'b0100; Val_Rn_in = 3; Shift_operand_in = 12'h003;
    wb_enable_in = 0; mem_write_enable_in = 1; Dest_in = 4'd4; Val_Rm_in = 32'h9999;
    step(); step();
    checks++;
    if (ALU_result !== 32'h80000000 || status_out !== 4'b1001 || Dest !== 4'd9 ||
        Val_Rm !== 32'h1234 || wb_enable !== 1'b1 || mem_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL freeze_hold: got res=%h st=%b dest=%h rm=%h wb=%b mw=%b required 80000000 1001 9 00001234 1 0",
               ALU_result, status_out, Dest, Val_Rm, wb_enable, mem_write_enable);
    end
    rst = 1;
    step();
    checks++;
    if ({wb_enable, mem_read_enable, mem_write_enable, ALU_result, Val_Rm, Dest, status_out} !== 75'd0) begin
      errors++;
      $display("FAIL reset_over_freeze: got ctl=%b%b%b res=%h rm=%h dest=%h st=%b required all zero",
               wb_enable, mem_read_enable, mem_write_enable, ALU_result, Val_Rm, Dest, status_out);
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_add_imm();
    test_sub_flags();
    test_add_overflow();
    test_adc_sbc();
    test_logic_flags();
    test_shifter();
    test_mem_offset();
    test_branch();
    test_bubble();
    test_back_to_back();
    test_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
